// File: rtl/cpu_pkg.sv
// Shared widths, types and the issue-register layout for the operand fetch stage.
package cpu_pkg;

   localparam int ADDR_WIDTH    = 3;
   localparam int DATA_WIDTH    = 16;
   localparam int REG_FILE_SIZE = 1 << ADDR_WIDTH;
   localparam int OP_WIDTH      = 5;

   typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [OP_WIDTH-1:0]   op_t;

   // Contents of the pipeline register handed to execute.
   typedef struct packed {
      op_t      op;
      word_t    a;
      word_t    b;
      reg_idx_t rd;
      logic     rd_we;
   } issue_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy-bit scoreboard for in-flight destination registers.
// A writeback in the current cycle hides the busy bit it is about to clear,
// and a new writer set on the same edge as a clear keeps the register busy.
module scoreboard
   import cpu_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     set_en,
   input  reg_idx_t set_addr,
   input  logic     clr_en,
   input  reg_idx_t clr_addr,
   input  reg_idx_t q1_addr,
   input  reg_idx_t q2_addr,
   input  reg_idx_t q3_addr,
   output logic     q1_busy,
   output logic     q2_busy,
   output logic     q3_busy
);

   logic [REG_FILE_SIZE-1:0] busy;

   // Clear on writeback, then set for the newly issued writer so set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (clr_en)
            busy[clr_addr] <= 1'b0;
         if (set_en)
            busy[set_addr] <= 1'b1;
      end
   end

   assign q1_busy = busy[q1_addr] && !(clr_en && (clr_addr == q1_addr));
   assign q2_busy = busy[q2_addr] && !(clr_en && (clr_addr == q2_addr));
   assign q3_busy = busy[q3_addr] && !(clr_en && (clr_addr == q3_addr));

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: drives register file read addresses, bypasses
// same-cycle writeback data, stalls on RAW/WAW hazards via the scoreboard and
// registers the operands into a valid/ready stage feeding execute.
// Optional macro ZERO_REG_EN makes register 0 a hardwired zero that is never
// busy and never written.
module operand_fetch
   import cpu_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     in_valid,
   output logic     in_ready,
   input  op_t      in_op,
   input  reg_idx_t in_rs1,
   input  reg_idx_t in_rs2,
   input  reg_idx_t in_rd,
   input  logic     in_rd_we,
   output reg_idx_t reg_r_addr_1,
   output reg_idx_t reg_r_addr_2,
   input  word_t    reg_r_data_1,
   input  word_t    reg_r_data_2,
   input  logic     wb_en,
   input  reg_idx_t wb_addr,
   input  word_t    wb_data,
   output logic     out_valid,
   input  logic     out_ready,
   output op_t      out_op,
   output word_t    out_a,
   output word_t    out_b,
   output reg_idx_t out_rd,
   output logic     out_rd_we
);

   issue_t out_reg;
   word_t  opnd_1;
   word_t  opnd_2;
   logic   rd_we_eff;
   logic   rs1_busy;
   logic   rs2_busy;
   logic   rd_busy;
   logic   hazard;
   logic   accept;

   assign reg_r_addr_1 = in_rs1;
   assign reg_r_addr_2 = in_rs2;

   // Operand selection: writeback bypass, with an optional hardwired zero register.
   always_comb begin
      opnd_1    = (wb_en && (wb_addr == in_rs1)) ? wb_data : reg_r_data_1;
      opnd_2    = (wb_en && (wb_addr == in_rs2)) ? wb_data : reg_r_data_2;
      rd_we_eff = in_rd_we;
`ifdef ZERO_REG_EN
      if (in_rs1 == '0)
         opnd_1 = '0;
      if (in_rs2 == '0)
         opnd_2 = '0;
      if (in_rd == '0)
         rd_we_eff = 1'b0;
`else
`endif
   end

   scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (accept && rd_we_eff),
      .set_addr (in_rd),
      .clr_en   (wb_en),
      .clr_addr (wb_addr),
      .q1_addr  (in_rs1),
      .q2_addr  (in_rs2),
      .q3_addr  (in_rd),
      .q1_busy  (rs1_busy),
      .q2_busy  (rs2_busy),
      .q3_busy  (rd_busy)
   );

   // Register 0 is never set busy under ZERO_REG_EN, so no special case is needed here.
   assign hazard   = in_valid && (rs1_busy || rs2_busy || (rd_we_eff && rd_busy));
   assign in_ready = !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Output pipeline register: load on accept, drop valid once execute takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_reg   <= '0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         out_reg.op    <= in_op;
         out_reg.a     <= opnd_1;
         out_reg.b     <= opnd_2;
         out_reg.rd    <= in_rd;
         out_reg.rd_we <= rd_we_eff;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_op    = out_reg.op;
   assign out_a     = out_reg.a;
   assign out_b     = out_reg.b;
   assign out_rd    = out_reg.rd;
   assign out_rd_we = out_reg.rd_we;

endmodule
